piso_serializer: RTL and testbench

Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `dout`, with per-bit qualifier and frame markers. It is the transmit end of the serial bit stream consumed by the team's serial-in shift-register and deserializer blocks, and sits between a parallel data source and a single-wire link.

---
 rtl/piso_pkg.sv | 30 +++
 rtl/piso_bit_counter.sv | 41 ++++
 rtl/piso_serializer.sv | 125 ++++++++++++
 tb/tb_piso_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in serial-out serializer.
//   piso_state_t : IDLE / SHIFT state encoding.
//   PARITY_BITS  : number of bits appended after the data bits.
//                  This is 1 when PISO_PARITY_EN is defined and 0 otherwise.
//   frame_len()  : serial frame length in bits for a given data width.
//   cnt_width()  : width of the bit-position counter for a given data width.
// Optional feature macro: PISO_PARITY_EN (even parity bit appended to each frame).
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Sized to hold WIDTH, so it also covers the parity position when enabled.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: tracks which bit of the current frame is on dout.
//   clk          in  rising-edge clock
//   reset        in  asynchronous active-low reset (count -> 0)
//   clear        in  restart at bit 0 (a new word is being loaded)
//   inc          in  advance to the next bit
//   is_last      out the current bit is the final bit of the frame (LEN-1)
//   next_is_last out the current bit is the next-to-last bit (LEN-2)
// The next_is_last output lets the parent register frame_last one cycle ahead.
// It also identifies the parity slot, because the parity bit is always the
// final bit of the frame.
module piso_bit_counter #(
  parameter int LEN = 8,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic is_last,
  output logic next_is_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
  localparam logic [CW-1:0] PEN_IDX  = CW'(LEN - 2);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign is_last      = (count_reg == LAST_IDX);
  assign next_is_last = (count_reg == PEN_IDX);

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word on a valid/ready handshake and
// shifts it out one bit per clock on dout. Each frame is marked with
// frame_first and frame_last.
//   clk          in  rising-edge clock
//   reset        in  asynchronous active-low reset
//   din          in  parallel word (sampled only at the transfer edge)
//   din_valid    in  din holds a word
//   din_ready    out word can be accepted this cycle (IDLE, or last bit on dout)
//   dout         out serial data bit (registered)
//   dout_valid   out dout carries a frame bit (registered)
//   frame_first  out first bit of a frame (registered)
//   frame_last   out last bit of a frame (registered)
//   busy         out frame in progress (state SHIFT)
// Parameters:
//   WIDTH        data width (must be at least 2)
//   MSB_FIRST    1 sends bit WIDTH-1 first; 0 sends bit 0 first
// Optional feature macro: PISO_PARITY_EN.
//   When defined, an even-parity bit follows the data bits.
//   That parity bit is marked by frame_last.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             busy
);

  localparam int LEN = frame_len(WIDTH);
  localparam int CW  = cnt_width(WIDTH);

  piso_state_t      state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic             is_last;
  logic             next_is_last;
  logic             xfer;
  logic             next_bit;

  // The bit that leaves the word first in the chosen bit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // The word with its head bit consumed.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends only on state and counter, so a new word can be accepted
  // while the last bit is on the wire. This gives gapless back-to-back frames.
  assign din_ready = (state_reg == IDLE) || is_last;
  assign xfer      = din_valid && din_ready;
  assign busy      = (state_reg == SHIFT);

  piso_bit_counter #(
    .LEN (LEN),
    .CW  (CW)
  ) u_bit_counter (
    .clk          (clk),
    .reset        (reset),
    .clear        (xfer),
    .inc          ((state_reg == SHIFT) && !is_last),
    .is_last      (is_last),
    .next_is_last (next_is_last)
  );

`ifdef PISO_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_reg <= 1'b0;
    end else if (xfer) begin
      parity_reg <= ^din;
    end
  end

  // The parity bit is the frame's final bit.
  // It therefore goes out right after the next-to-last position.
  assign next_bit = next_is_last ? parity_reg : head_bit(shift_reg);
`else
  assign next_bit = head_bit(shift_reg);
`endif

  // The first bit is driven straight from din at the transfer edge.
  // shift_reg therefore only holds the bits still to be sent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end else if (xfer) begin
      state_reg   <= SHIFT;
      shift_reg   <= advance(din);
      dout        <= head_bit(din);
      dout_valid  <= 1'b1;
      frame_first <= 1'b1;
      frame_last  <= 1'b0;
    end else if ((state_reg == SHIFT) && !is_last) begin
      shift_reg   <= advance(shift_reg);
      dout        <= next_bit;
      frame_first <= 1'b0;
      frame_last  <= next_is_last;
    end else begin
      state_reg   <= IDLE;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: two serializers (MSB-first and LSB-first) share one
// input stream. Each accepted word is expanded into its expected bit sequence
// and queued. A negedge monitor pops each queue while dout_valid is high.
// It also checks idle behaviour, din_ready and busy.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic din_ready_w[2];
  logic dout_w[2];
  logic dv_w[2];
  logic ff_w[2];
  logic fl_w[2];
  logic busy_w[2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   words = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    piso_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1 - gi)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready_w[gi]),
      .dout        (dout_w[gi]),
      .dout_valid  (dv_w[gi]),
      .frame_first (ff_w[gi]),
      .frame_last  (fl_w[gi]),
      .busy        (busy_w[gi])
    );
  end

  // Instance 0 is MSB-first; instance 1 is LSB-first.
  task automatic chk(input string name, input int m, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, m, act, exp, $time);
    end
  endtask

  // Reference: bit k of a frame from the word, bit order and parity rule.
  function automatic exp_t model_bit(input logic [W-1:0] w, input int msb, input int k);
    exp_t e;
    if (k >= W) e.b = ^w;
    else if (msb != 0) e.b = w[W-1-k];
    else e.b = w[k];
    e.first = (k == 0);
    e.last  = (k == L - 1);
    return e;
  endfunction

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int m);
    if (m == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Monitor and scoreboard. Checks run before pushing, so a word accepted at
  // the coming edge is appended only after the current bit is consumed.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q0.delete();
      q1.delete();
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (dv_w[m]) begin
          if (qsize(m) == 0) begin
            chk("unexpected_bit", m, 1, 0);
          end else begin
            e = qpop(m);
            chk("dout", m, dout_w[m], e.b);
            chk("frame_first", m, ff_w[m], e.first);
            chk("frame_last", m, fl_w[m], e.last);
            chk("din_ready_busy", m, din_ready_w[m], e.last);
          end
        end else begin
          chk("gap_pending_bits", m, qsize(m), 0);
          chk("idle_dout", m, dout_w[m], 0);
          chk("idle_first", m, ff_w[m], 0);
          chk("idle_last", m, fl_w[m], 0);
          chk("idle_ready", m, din_ready_w[m], 1);
        end
        chk("busy", m, busy_w[m], dv_w[m]);
      end
      if (din_valid && din_ready_w[0]) begin
        for (int k = 0; k < L; k++) begin
          q0.push_back(model_bit(din, 1, k));
          q1.push_back(model_bit(din, 0, k));
        end
        words++;
        $display("tx %0d: word=%h accepted at %0t", words, din, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word until it is accepted, then scramble din to confirm it is ignored.
  task automatic send(input logic [W-1:0] w);
    int n = 0;
    din = w;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready_w[0] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: din_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_w[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy stayed 1 for %0d cycles, required 0", n);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_dout_valid", m, dv_w[m], 0);
      chk("rst_dout", m, dout_w[m], 0);
      chk("rst_busy", m, busy_w[m], 0);
      chk("rst_first", m, ff_w[m], 0);
      chk("rst_last", m, fl_w[m], 0);
    end
    reset = 1'b1;
    tick();

    send(8'hA5); wait_idle();
    send(8'h01); wait_idle();
    send(8'hFF); send(8'h00); wait_idle();
    send(8'h07); wait_idle();
    // Offer a word while the previous frame is mid-flight.
    send(8'hA5); repeat (3) tick(); send(8'h3C); wait_idle();

    // Asynchronous reset at bit 4 of a frame.
    send(8'hA5);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("midrst_dout_valid", m, dv_w[m], 0);
      chk("midrst_dout", m, dout_w[m], 0);
      chk("midrst_busy", m, busy_w[m], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int m = 0; m < 2; m++) chk("postrst_ready", m, din_ready_w[m], 1);
    send(8'hC3); wait_idle();

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(W'($urandom));
    end
    wait_idle();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
